// File: rtl/delaychain_pkg.sv
// Shared definitions for the delay-chain sweep controller: FSM states,
// sample-latency limits and counter saturation helper.
package delaychain_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_LAUNCH = 3'd2,
      ST_WAIT   = 3'd3,
      ST_CHECK  = 3'd4,
      ST_NEXT   = 3'd5,
      ST_DONE   = 3'd6
   } state_e;

   // controller output register + chain input flop + chain output flop
   localparam int unsigned CHECK_DLY_MIN = 3;
   localparam int unsigned CHECK_DLY_MAX = 15;

   function automatic int unsigned sat_max(input int unsigned w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

endpackage

// File: rtl/delaychain_sweep_ctrl_if.sv
// Host-side control/readback bundle of the sweep controller.
// fail_chain/fail_iter exist only with DELAYCHAIN_STOP_ON_ERR_EN.
interface delaychain_sweep_ctrl_if #(
   parameter int unsigned N      = 4,
   parameter int unsigned ITER_W = 8,
   parameter int unsigned CNT_W  = 8
);
   localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

   logic              start;
   logic [ITER_W-1:0] num_iter;
   logic [SEL_W-1:0]  rd_sel;
   logic [CNT_W-1:0]  rd_errcnt;
   logic              busy;
   logic              done;
   logic              fail;
`ifdef DELAYCHAIN_STOP_ON_ERR_EN
   logic [SEL_W-1:0]  fail_chain;
   logic [ITER_W-1:0] fail_iter;

   modport master (output start, num_iter, rd_sel,
                   input  rd_errcnt, busy, done, fail, fail_chain, fail_iter);
   modport slave  (input  start, num_iter, rd_sel,
                   output rd_errcnt, busy, done, fail, fail_chain, fail_iter);
`else
   modport master (output start, num_iter, rd_sel,
                   input  rd_errcnt, busy, done, fail);
   modport slave  (input  start, num_iter, rd_sel,
                   output rd_errcnt, busy, done, fail);
`endif
endinterface

// File: rtl/delaychain_errcnt.sv
// Saturating per-chain mismatch counter with synchronous clear.
module delaychain_errcnt
   import delaychain_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);
   localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_max(CNT_W));

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (inc && (cnt_q != SAT))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/delaychain_sweep_ctrl.sv
// Sweeps N delay-chain instances with alternating edges and counts mismatches.
// Define DELAYCHAIN_STOP_ON_ERR_EN to abort the sweep on the first mismatch.
module delaychain_sweep_ctrl
   import delaychain_pkg::*;
#(
   parameter int unsigned N         = 4,
   parameter int unsigned ITER_W    = 8,
   parameter int unsigned CNT_W     = 8,
   parameter int unsigned CHECK_DLY = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   delaychain_sweep_ctrl_if.slave  host,
   output logic [N-1:0]            din_o,
   output logic [N-1:0]            test_o,
   input  logic [N-1:0]            dout_i
);
   localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned DLY   = (CHECK_DLY < CHECK_DLY_MIN) ? CHECK_DLY_MIN :
                                   (CHECK_DLY > CHECK_DLY_MAX) ? CHECK_DLY_MAX : CHECK_DLY;
   localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(N - 1);

   state_e            state_q, state_d;
   logic [SEL_W-1:0]  chan_q, chan_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [ITER_W-1:0] num_q, num_d;
   logic [3:0]        dly_q, dly_d;
   logic              exp_q, exp_d;
   logic [N-1:0]      din_q, din_d;
   logic [N-1:0]      test_q, test_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              fail_q, fail_d;
`ifdef DELAYCHAIN_STOP_ON_ERR_EN
   logic [SEL_W-1:0]  fchain_q, fchain_d;
   logic [ITER_W-1:0] fiter_q, fiter_d;
   logic              stop_q, stop_d;
`endif

   logic              clr;
   logic [N-1:0]      inc;
   logic [CNT_W-1:0]  cnt [N];
   logic              any_err;
   logic              mism;
   logic              last;
   logic [ITER_W:0]   iter_nxt;
   logic [CNT_W-1:0]  rd_errcnt;

   for (genvar g = 0; g < N; g++) begin : g_cnt
      delaychain_errcnt #(.CNT_W(CNT_W)) u_errcnt (
         .clk (clk),
         .rst (rst),
         .clr (clr),
         .inc (inc[g]),
         .cnt (cnt[g])
      );
   end

   always_comb begin
      any_err = 1'b0;
      for (int unsigned i = 0; i < N; i++)
         if (cnt[i] != '0) any_err = 1'b1;
   end

   always_comb begin
      rd_errcnt = '0;
      for (int unsigned i = 0; i < N; i++)
         if (host.rd_sel == SEL_W'(i)) rd_errcnt = cnt[i];
   end

   assign mism = dout_i[chan_q] ^ exp_q;

   always_comb begin
      state_d  = state_q;
      chan_d   = chan_q;
      iter_d   = iter_q;
      num_d    = num_q;
      dly_d    = dly_q;
      exp_d    = exp_q;
      din_d    = din_q;
      test_d   = test_q;
      fail_d   = fail_q;
      clr      = 1'b0;
      inc      = '0;
      iter_nxt = {1'b0, iter_q} + (ITER_W+1)'(1);
`ifdef DELAYCHAIN_STOP_ON_ERR_EN
      fchain_d = fchain_q;
      fiter_d  = fiter_q;
      stop_d   = stop_q;
      last     = (chan_q == LAST_CHAN) || stop_q;
`else
      last     = (chan_q == LAST_CHAN);
`endif

      unique case (state_q)
         ST_IDLE: begin
            if (host.start) begin
               num_d   = host.num_iter;
               clr     = 1'b1;
               fail_d  = 1'b0;
               chan_d  = '0;
               iter_d  = '0;
               dly_d   = '0;
`ifdef DELAYCHAIN_STOP_ON_ERR_EN
               fchain_d = '0;
               fiter_d  = '0;
               stop_d   = 1'b0;
`endif
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            test_d         = '0;
            test_d[chan_q] = 1'b1;
            din_d          = '0;
            if (dly_q == 4'(DLY - 1)) begin
               dly_d   = '0;
               state_d = (num_q == '0) ? ST_NEXT : ST_LAUNCH;
            end else begin
               dly_d = dly_q + 4'd1;
            end
         end
         ST_LAUNCH: begin
            din_d[chan_q] = ~din_q[chan_q];
            exp_d         = ~din_q[chan_q];
            dly_d         = '0;
            state_d       = ST_WAIT;
         end
         // LAUNCH plus DLY-1 WAIT cycles places CHECK at launch + DLY
         ST_WAIT: begin
            if (dly_q == 4'(DLY - 2)) begin
               dly_d   = '0;
               state_d = ST_CHECK;
            end else begin
               dly_d = dly_q + 4'd1;
            end
         end
         ST_CHECK: begin
            inc[chan_q] = mism;
            iter_d      = iter_nxt[ITER_W-1:0];
            state_d     = (iter_nxt < {1'b0, num_q}) ? ST_LAUNCH : ST_NEXT;
`ifdef DELAYCHAIN_STOP_ON_ERR_EN
            if (mism) begin
               fchain_d = chan_q;
               fiter_d  = iter_q;
               stop_d   = 1'b1;
               state_d  = ST_NEXT;
            end
`endif
         end
         ST_NEXT: begin
            din_d  = '0;
            test_d = '0;
            iter_d = '0;
            if (last) begin
               fail_d  = any_err;
               state_d = ST_DONE;
            end else begin
               chan_d  = chan_q + SEL_W'(1);
               state_d = ST_SETUP;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         chan_q   <= '0;
         iter_q   <= '0;
         num_q    <= '0;
         dly_q    <= '0;
         exp_q    <= 1'b0;
         din_q    <= '0;
         test_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fail_q   <= 1'b0;
`ifdef DELAYCHAIN_STOP_ON_ERR_EN
         fchain_q <= '0;
         fiter_q  <= '0;
         stop_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         chan_q   <= chan_d;
         iter_q   <= iter_d;
         num_q    <= num_d;
         dly_q    <= dly_d;
         exp_q    <= exp_d;
         din_q    <= din_d;
         test_q   <= test_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         fail_q   <= fail_d;
`ifdef DELAYCHAIN_STOP_ON_ERR_EN
         fchain_q <= fchain_d;
         fiter_q  <= fiter_d;
         stop_q   <= stop_d;
`endif
      end
   end

   assign din_o          = din_q;
   assign test_o         = test_q;
   assign host.busy      = busy_q;
   assign host.done      = done_q;
   assign host.fail      = fail_q;
   assign host.rd_errcnt = rd_errcnt;
`ifdef DELAYCHAIN_STOP_ON_ERR_EN
   assign host.fail_chain = fchain_q;
   assign host.fail_iter  = fiter_q;
`endif
endmodule

// File: tb/tb_delaychain_sweep_ctrl.sv
// Randomized scoreboard bench for delaychain_sweep_ctrl with faulty-chain models.
// Honours DELAYCHAIN_STOP_ON_ERR_EN when defined.
module tb_delaychain_sweep_ctrl;
   localparam int unsigned N      = 6;
   localparam int unsigned ITER_W = 8;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned D      = 3;
   localparam int unsigned SEL_W  = $clog2(N);
   localparam int unsigned CMAX   = (1 << CNT_W) - 1;

   typedef enum int unsigned {K_OK, K_DLY, K_S0, K_S1, K_INV} kind_e;

   typedef struct {
      logic [N-1:0][CNT_W-1:0] cnt;
      bit          fail;
      bit          abort;
      int unsigned busy;
      int unsigned rises;
      int unsigned fchain;
      int unsigned fiter;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] din_o, test_o, dout;

   delaychain_sweep_ctrl_if #(.N(N), .ITER_W(ITER_W), .CNT_W(CNT_W)) hif ();

   delaychain_sweep_ctrl #(.N(N), .ITER_W(ITER_W), .CNT_W(CNT_W), .CHECK_DLY(D)) dut (
      .clk    (clk),
      .rst    (rst),
      .host   (hif),
      .din_o  (din_o),
      .test_o (test_o),
      .dout_i (dout)
   );

   always #10 clk = ~clk;

   kind_e       kind [N];
   int unsigned inv_from [N];
   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   int unsigned mon_cnt = 0;
   int unsigned issued = 0;
   int unsigned abort_req = 0;
   exp_t        sb_q [$];

   // chain models: input flop, output flop, optional extra delay flop
   logic [N-1:0] p1, p2, p3;
   int unsigned  ntog [N];

   always @(posedge clk) begin
      p1 <= din_o;
      p2 <= p1;
      p3 <= p2;
      for (int i = 0; i < N; i++) begin
         if (rst || (hif.start && !hif.busy)) ntog[i] <= 0;
         else if (p1[i] != p2[i])             ntog[i] <= ntog[i] + 1;
      end
   end

   always_comb begin
      dout = '0;
      for (int i = 0; i < N; i++) begin
         case (kind[i])
            K_DLY:   dout[i] = p3[i];
            K_S0:    dout[i] = 1'b0;
            K_S1:    dout[i] = 1'b1;
            K_INV:   dout[i] = p2[i] ^ (ntog[i] >= inv_from[i] + 1);
            default: dout[i] = p2[i];
         endcase
      end
   end

   task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: each iteration k expects level (k even); the observed level follows the fault kind.
   function automatic exp_t model(input int unsigned num);
      exp_t        e;
      int unsigned errs;
      bit          stop, lvl, obs;
      e.cnt = '0; e.fail = 0; e.abort = 0; e.busy = 0; e.rises = 0; e.fchain = 0; e.fiter = 0;
      stop = 0;
      for (int unsigned c = 0; c < N && !stop; c++) begin
         e.busy += D + 1;
         errs = 0;
         for (int unsigned k = 0; k < num; k++) begin
            lvl = (k % 2 == 0);
            e.busy += D + 1;
            if (lvl) e.rises++;
            case (kind[c])
               K_DLY:   obs = (D >= 4) ? lvl : !lvl;
               K_S0:    obs = 1'b0;
               K_S1:    obs = 1'b1;
               K_INV:   obs = (k >= inv_from[c]) ? !lvl : lvl;
               default: obs = lvl;
            endcase
            if (obs != lvl) begin
               errs++;
`ifdef DELAYCHAIN_STOP_ON_ERR_EN
               e.fchain = c;
               e.fiter  = k;
               stop     = 1;
               break;
`endif
            end
         end
         e.cnt[c] = CNT_W'((errs > CMAX) ? CMAX : errs);
      end
      e.fail = (e.cnt != '0);
      return e;
   endfunction

   task automatic readback(input exp_t e);
      for (int unsigned s = 0; s < (1 << SEL_W); s++) begin
         hif.rd_sel = SEL_W'(s);
         #1;
         chk($sformatf("rd_errcnt[%0d]", s), hif.rd_errcnt, (s < N) ? e.cnt[s] : 0);
      end
      hif.rd_sel = '0;
   endtask

   // monitor / scoreboard
   initial begin
      logic [N-1:0] prev_din;
      logic         prev_busy;
      int unsigned  busy_run, rises, abort_seen;
      exp_t         e;
      prev_din = '0; prev_busy = 0; busy_run = 0; rises = 0; abort_seen = 0;
      hif.rd_sel = '0;
      forever begin
         @(negedge clk);
         n_checks++;
         if (!$onehot0(test_o) || ((din_o & ~test_o) != '0)) begin
            n_fail++;
            $display("FAIL chain_isolation test_o=%b din_o=%b", test_o, din_o);
         end
         if (hif.busy && !prev_busy) chk("fail_clear_on_start", hif.fail, 0);
         if (hif.busy) busy_run++;
         rises += $countones(din_o & ~prev_din);
         prev_din  = din_o;
         prev_busy = hif.busy;
         if (hif.done) begin
            if (sb_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               e = sb_q.pop_front();
               chk("done_not_aborted", e.abort, 0);
               chk("fail", hif.fail, e.fail);
               chk("busy_cycles", busy_run, e.busy);
               chk("din_rises", rises, e.rises);
`ifdef DELAYCHAIN_STOP_ON_ERR_EN
               chk("fail_chain", hif.fail_chain, e.fchain);
               chk("fail_iter", hif.fail_iter, e.fiter);
`endif
               readback(e);
            end
            busy_run = 0; rises = 0;
            mon_cnt++;
         end else if (abort_req != abort_seen) begin
            abort_seen++;
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               chk("abort_record", e.abort, 1);
               readback(e);
            end
            busy_run = 0; rises = 0;
            mon_cnt++;
         end
      end
   end

   task automatic wait_mon(input int unsigned budget);
      int unsigned n = 0;
      while (mon_cnt < issued && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("sweep_timeout", (mon_cnt >= issued), 1);
      if (mon_cnt < issued) begin
         sb_q.delete();
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         issued = mon_cnt;
      end
   endtask

   task automatic run_sweep(input int unsigned num, input bit inject);
      exp_t e;
      e = model(num);
      sb_q.push_back(e);
      issued++;
      @(negedge clk);
      hif.start = 1'b1;
      hif.num_iter = ITER_W'(num);
      @(negedge clk);
      hif.start = 1'b0;
      hif.num_iter = ITER_W'($urandom);
      if (inject) begin
         repeat (5) @(negedge clk);
         hif.start = 1'b1;
         hif.num_iter = ITER_W'(num + 3);
         @(negedge clk);
         hif.start = 1'b0;
      end
      wait_mon(e.busy + 40);
   endtask

   task automatic all_ok();
      for (int i = 0; i < N; i++) begin
         kind[i] = K_OK;
         inv_from[i] = 0;
      end
   endtask

   task automatic reset_in_wait();
      exp_t        e;
      int unsigned n = 0;
      all_ok();
      kind[0] = K_S0;
      @(negedge clk);
      hif.start = 1'b1;
      hif.num_iter = ITER_W'(6);
      @(negedge clk);
      hif.start = 1'b0;
      while (!din_o[1] && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("reached_chain1_wait", din_o[1], 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_din_o", din_o, 0);
      chk("abort_test_o", test_o, 0);
      chk("abort_busy", hif.busy, 0);
      chk("abort_done", hif.done, 0);
      chk("abort_fail", hif.fail, 0);
      rst = 1'b0;
      e.cnt = '0; e.fail = 0; e.abort = 1; e.busy = 0; e.rises = 0; e.fchain = 0; e.fiter = 0;
      sb_q.push_back(e);
      issued++;
      abort_req++;
      wait_mon(20);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      hif.start = 1'b0;
      hif.num_iter = '0;
      all_ok();
      repeat (3) @(negedge clk);
      chk("reset_din_o", din_o, 0);
      chk("reset_test_o", test_o, 0);
      chk("reset_busy", hif.busy, 0);
      chk("reset_done", hif.done, 0);
      chk("reset_fail", hif.fail, 0);
      chk("reset_rd_errcnt", hif.rd_errcnt, 0);
      rst = 1'b0;

      all_ok();
      run_sweep(6, 0);
      kind[2] = K_DLY;
      run_sweep(6, 0);
      all_ok();
      kind[1] = K_S0;
      run_sweep(255, 0);
      all_ok();
      kind[4] = K_S1;
      run_sweep(0, 0);
      reset_in_wait();
`ifdef DELAYCHAIN_STOP_ON_ERR_EN
      all_ok();
      kind[3] = K_INV;
      inv_from[3] = 2;
      run_sweep(6, 0);
`endif
      all_ok();
      kind[5] = K_S1;
      run_sweep(7, 1);
      for (int r = 0; r < 20; r++) begin
         for (int i = 0; i < N; i++) begin
            kind[i] = ($urandom_range(0, 3) == 0) ? kind_e'($urandom_range(1, 4)) : K_OK;
            inv_from[i] = $urandom_range(0, 5);
         end
         run_sweep($urandom_range(0, 12), (r % 5) == 2);
      end
      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
